// File: rtl/main_tb_pkg.sv
// Shared types and sizing helpers for the main accelerator preload/run controller.
package main_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_REPORT
  } state_t;

  localparam int unsigned MAX_CYCLES_DEFAULT = 200000000;
  localparam int          NUM_CH             = 2;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Lane counter must represent 0..LANES inclusive.
  function automatic int lane_cnt_w(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

endpackage

// File: rtl/main_preload_run_ctrl_packer.sv
// Packs a little-endian byte stream into one slave memory word; unused lanes stay zero.
module byte_word_packer
  import main_tb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7,
  localparam int LANES = lanes_of(DATA_W),
  localparam int NW    = lane_cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_take,
  input  logic [7:0]        i_byte,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_word,
  output logic [NW-1:0]     o_cnt,
  output logic              o_last_lane,
  output logic [SIZE_W-1:0] o_size
);

  logic [DATA_W-1:0] r_word;
  logic [NW-1:0]     r_cnt;
  logic [LANES-1:0]  r_lane_oh;

  // One-hot lane pointer selects the byte slot written by the next accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_cnt     <= '0;
      r_lane_oh <= LANES'(1);
    end else if (i_flush) begin
      r_word    <= '0;
      r_cnt     <= '0;
      r_lane_oh <= LANES'(1);
    end else if (i_take) begin
      for (int l = 0; l < LANES; l++) begin
        if (r_lane_oh[l]) r_word[l*8 +: 8] <= i_byte;
      end
      r_cnt     <= r_cnt + NW'(1);
      r_lane_oh <= r_lane_oh << 1;
    end
  end

  assign o_word      = r_word;
  assign o_cnt       = r_cnt;
  assign o_last_lane = (r_cnt == NW'(LANES - 1));
  assign o_size      = SIZE_W'({r_cnt, 3'b000});

endmodule

// File: rtl/main_preload_run_ctrl.sv
// Preloads main's memory over slave channel 0, pulses start_port, and measures cycles to done_port.
module main_preload_run_ctrl
  import main_tb_pkg::*;
#(
  parameter int          ADDR_W     = 9,
  parameter int          DATA_W     = 64,
  parameter int          SIZE_W     = 7,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  go_skip_preload,
  input  logic                  s_byte_valid,
  input  logic [7:0]            s_byte_data,
  input  logic                  s_byte_last,
  output logic                  s_byte_ready,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CNT_W-1:0]      result_cycles,
  output logic                  result_timeout
);

  localparam int NW = lane_cnt_w(DATA_W);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_inc;
  logic              r_last_seen;
  logic              r_result_valid;
  logic [CNT_W-1:0]  r_result_cycles;
  logic              r_result_timeout;

  logic              w_take, w_wr_acc, w_go, w_limit, w_flush;
  logic [DATA_W-1:0] w_word;
  logic [NW-1:0]     w_cnt;
  logic              w_last_lane;
  logic [SIZE_W-1:0] w_size;
  logic              w_unused;

  assign w_unused    = Sout_DataRdy[1];
  assign w_take      = (r_state == ST_FILL) && s_byte_valid;
  assign w_wr_acc    = (r_state == ST_WRITE) && Sout_DataRdy[0];
  assign w_go        = (r_state == ST_IDLE) && go;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_limit     = (w_count_inc == CNT_W'(MAX_CYCLES));
  assign w_flush     = w_wr_acc || w_go;

  byte_word_packer #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_packer (
    .clk         (clock),
    .rst_n       (reset),
    .i_take      (w_take),
    .i_byte      (s_byte_data),
    .i_flush     (w_flush),
    .o_word      (w_word),
    .o_cnt       (w_cnt),
    .o_last_lane (w_last_lane),
    .o_size      (w_size)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (go) w_next = go_skip_preload ? ST_START : ST_FILL;
      ST_FILL:   if (w_take && (w_last_lane || s_byte_last)) w_next = ST_WRITE;
      ST_WRITE:  if (Sout_DataRdy[0]) w_next = r_last_seen ? ST_START : ST_FILL;
      ST_START:  w_next = ST_RUN;
      ST_RUN:    if (done_port || w_limit) w_next = ST_REPORT;
      ST_REPORT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Slave bus is driven only while a write is pending; channel 1 is tied off.
  always_comb begin
    s_byte_ready    = (r_state == ST_FILL);
    start_port      = (r_state == ST_START);
    busy            = (r_state != ST_IDLE);
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (r_state == ST_WRITE) begin
      S_we_ram        = 2'b01;
      S_addr_ram      = {ADDR_W'(0), r_addr};
      S_Wdata_ram     = {DATA_W'(0), w_word};
      S_data_ram_size = {SIZE_W'(0), w_size};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr           <= '0;
      r_count          <= '0;
      r_last_seen      <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_cycles  <= '0;
      r_result_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (go) begin
          r_addr           <= ADDR_W'(BASE_ADDR);
          r_count          <= '0;
          r_last_seen      <= 1'b0;
          r_result_valid   <= 1'b0;
          r_result_cycles  <= '0;
          r_result_timeout <= 1'b0;
        end
        ST_FILL:  if (w_take && s_byte_last) r_last_seen <= 1'b1;
        ST_WRITE: if (Sout_DataRdy[0]) r_addr <= r_addr + ADDR_W'(w_cnt);
        ST_START: r_count <= '0;
        ST_RUN: begin
          r_count <= w_count_inc;
          // done wins over the timeout when both land on the same cycle
          if (done_port) begin
            r_result_cycles <= w_count_inc;
            r_result_valid  <= 1'b1;
          end else if (w_limit) begin
            r_result_cycles  <= CNT_W'(MAX_CYCLES);
            r_result_timeout <= 1'b1;
            r_result_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid   = r_result_valid;
  assign result_cycles  = r_result_cycles;
  assign result_timeout = r_result_timeout;

endmodule

// File: tb/tb_main_preload_run_ctrl.sv
// Directed bench for main_preload_run_ctrl: preload images, run timing, timeout and async reset.
module tb_main_preload_run_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;
  localparam int CNT_W  = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                go = 1'b0, go_skip_preload = 1'b0;
  logic                s_byte_valid = 1'b0, s_byte_last = 1'b0;
  logic [7:0]          s_byte_data = 8'h00;
  logic                s_byte_ready;
  logic [1:0]          S_oe_ram, S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [2*DATA_W-1:0] S_Wdata_ram;
  logic [2*SIZE_W-1:0] S_data_ram_size;
  logic [1:0]          Sout_DataRdy = 2'b00;
  logic                start_port;
  logic                done_port = 1'b0;
  logic                busy, result_valid, result_timeout;
  logic [CNT_W-1:0]    result_cycles;

  main_preload_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .BASE_ADDR(0), .CNT_W(CNT_W), .MAX_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .go_skip_preload(go_skip_preload),
    .s_byte_valid(s_byte_valid), .s_byte_data(s_byte_data), .s_byte_last(s_byte_last),
    .s_byte_ready(s_byte_ready), .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram),
    .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_DataRdy(Sout_DataRdy), .start_port(start_port), .done_port(done_port),
    .busy(busy), .result_valid(result_valid), .result_cycles(result_cycles),
    .result_timeout(result_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_total = 0;

  always @(posedge clock) if (S_we_ram[0]) we_total++;

  logic [7:0]  img [0:31];
  int          nw, g_cyc, first_we_cyc, last_cyc, start_cyc;
  logic [8:0]  w_addr_f [0:3], w_addr_l [0:3];
  logic [63:0] w_data_f [0:3], w_data_l [0:3];
  logic [6:0]  w_size_f [0:3];
  int          we_cyc [0:3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Issues go, streams img[0..nb-1], acknowledges each write after 'delay' wait cycles.
  // Returns on the start_port cycle, or with the bus held on write 'stop_w'.
  task automatic run_image(input int nb, input int delay, input int stop_w);
    int idx = 0;
    int wc = 0;
    bit fin = 0;
    nw = 0; first_we_cyc = -1; last_cyc = -1; start_cyc = -1;
    go = 1'b1; go_skip_preload = 1'b0; g_cyc = cyc;
    tick();
    go = 1'b0;
    chk("go_clears_valid", result_valid, 0);
    chk("go_clears_timeout", result_timeout, 0);
    for (int k = 0; k < 300 && !fin; k++) begin
      if (start_port) begin
        start_cyc = cyc;
        fin = 1;
      end else begin
        if (S_we_ram[0]) begin
          if (wc == 0) begin
            if (first_we_cyc < 0) first_we_cyc = cyc;
            w_addr_f[nw] = S_addr_ram[8:0];
            w_data_f[nw] = S_Wdata_ram[63:0];
            w_size_f[nw] = S_data_ram_size[6:0];
          end
          if (nw == stop_w) begin
            fin = 1;
          end else if (wc >= delay) begin
            Sout_DataRdy = 2'b01;
            w_addr_l[nw] = S_addr_ram[8:0];
            w_data_l[nw] = S_Wdata_ram[63:0];
            we_cyc[nw] = wc + 1;
            nw++;
            wc = 0;
          end else begin
            Sout_DataRdy = 2'b00;
            wc++;
          end
        end else begin
          Sout_DataRdy = 2'b00;
        end
        if (!fin && s_byte_ready && idx < nb) begin
          s_byte_valid = 1'b1;
          s_byte_data  = img[idx];
          s_byte_last  = (idx == nb - 1);
          if (idx == nb - 1) last_cyc = cyc;
          idx++;
        end else begin
          s_byte_valid = 1'b0;
          s_byte_last  = 1'b0;
        end
      end
      if (!fin) tick();
    end
    s_byte_valid = 1'b0;
    s_byte_last  = 1'b0;
    Sout_DataRdy = 2'b00;
    chk("image_reached_target", fin, 1);
  endtask

  // Called on the start_port cycle; raises done_port on the n-th RUN cycle.
  task automatic run_done(input int n, input bit pre_done);
    done_port = pre_done;
    tick();
    done_port = 1'b0;
    repeat (n - 1) tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    chk("report_valid", result_valid, 1);
    chk("report_cycles", result_cycles, n);
    chk("report_timeout", result_timeout, 0);
    chk("report_busy", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid_held", result_valid, 1);
  endtask

  initial begin
    int we_before;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_byte_ready, 0);
    chk("rst_we", S_we_ram, 0);
    chk("rst_oe", S_oe_ram, 0);
    chk("rst_start", start_port, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_cycles", result_cycles, 0);
    chk("rst_timeout", result_timeout, 0);
    #10 reset = 1'b1;
    tick();

    // 16 bytes 0x00..0x0F, immediate acknowledge
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    run_image(16, 0, -1);
    chk("t1_nwrites", nw, 2);
    chk("t1_addr0", w_addr_f[0], 9'd0);
    chk("t1_data0", w_data_f[0], 64'h0706050403020100);
    chk("t1_size0", w_size_f[0], 7'd64);
    chk("t1_addr1", w_addr_f[1], 9'd8);
    chk("t1_data1", w_data_f[1], 64'h0F0E0D0C0B0A0908);
    chk("t1_size1", w_size_f[1], 7'd64);
    chk("t1_go_to_we", first_we_cyc - g_cyc, 9);
    chk("t1_last_to_start", start_cyc - last_cyc, 2);
    run_done(5, 1'b0);

    // 3-byte partial word
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    run_image(3, 0, -1);
    chk("t2_nwrites", nw, 1);
    chk("t2_addr", w_addr_f[0], 9'd0);
    chk("t2_data", w_data_f[0], 64'h0000000000CCBBAA);
    chk("t2_size", w_size_f[0], 7'd24);
    chk("t2_last_to_start", start_cyc - last_cyc, 2);
    run_done(3, 1'b0);

    // acknowledge delayed by 5 cycles
    for (int i = 0; i < 8; i++) img[i] = 8'(8'h10 + i);
    run_image(8, 5, -1);
    chk("t3_we_cycles", we_cyc[0], 6);
    chk("t3_addr_first", w_addr_f[0], 9'd0);
    chk("t3_data_first", w_data_f[0], 64'h1716151413121110);
    chk("t3_addr_last", w_addr_l[0], 9'd0);
    chk("t3_data_last", w_data_l[0], 64'h1716151413121110);
    run_done(2, 1'b0);

    // skip preload; done already high in START is ignored
    we_before = we_total;
    go = 1'b1; go_skip_preload = 1'b1;
    tick();
    go = 1'b0; go_skip_preload = 1'b0;
    chk("t4_start", start_port, 1);
    chk("t4_valid_cleared", result_valid, 0);
    run_done(10, 1'b1);
    chk("t4_no_writes", we_total - we_before, 0);

    // timeout at MAX_CYCLES=50
    go = 1'b1; go_skip_preload = 1'b1;
    tick();
    go = 1'b0; go_skip_preload = 1'b0;
    chk("t5_start", start_port, 1);
    repeat (50) tick();
    chk("t5_valid_before", result_valid, 0);
    tick();
    chk("t5_valid", result_valid, 1);
    chk("t5_timeout", result_timeout, 1);
    chk("t5_cycles", result_cycles, 50);
    repeat (3) tick();
    chk("t5_valid_held", result_valid, 1);
    chk("t5_idle", busy, 0);

    // reset pulled during the second write of a 10-byte image
    for (int i = 0; i < 10; i++) img[i] = 8'(8'h30 + i);
    run_image(10, 0, 1);
    chk("t6_addr_pending", w_addr_f[1], 9'd8);
    chk("t6_we_pending", S_we_ram, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_we", S_we_ram, 0);
    chk("t6_rst_addr", S_addr_ram, 0);
    chk("t6_rst_data", S_Wdata_ram[63:0], 0);
    chk("t6_rst_size", S_data_ram_size, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", result_valid, 0);
    #2 reset = 1'b1;
    tick();
    img[0] = 8'h5A; img[1] = 8'hA5;
    run_image(2, 0, -1);
    chk("t6_nwrites", nw, 1);
    chk("t6_addr", w_addr_f[0], 9'd0);
    chk("t6_data", w_data_f[0], 64'h000000000000A55A);
    chk("t6_size", w_size_f[0], 7'd16);
    run_done(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
